ram_loader: RTL

RAM_LOADER -- requirements
Module: ram_loader

---
 rtl/ram_loader_pkg.sv | 21 ++
 rtl/ram_loader.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/ram_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_loader_pkg
// Description : Shared widths and FSM state encoding for the stream-to-RAM
//               loader.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_loader_pkg;

    localparam int c_ADDR_W = 12;
    localparam int c_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_VERIFY = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ram_loader.sv
`default_nettype none
// ============================================================================
// Module      : ram_loader
// Description : Streams bytes into an external RAM, then reads the range back
//               and compares the readback sum against the write checksum.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W,
    parameter int DATA_W = c_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum,
    output logic              err
);

    localparam logic [ADDR_W:0] c_CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] c_CNT_ZERO = '0;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  r_base;
    logic [ADDR_W:0]    r_len;
    logic [ADDR_W:0]    r_idx;
    logic [DATA_W-1:0]  r_checksum;
    logic [DATA_W-1:0]  r_rdsum;
    logic               r_err;

    logic               w_accept;
    logic               w_xfer;
    logic               w_last;
    logic [DATA_W-1:0]  w_rdsum_nxt;

    // idx is one bit wider than the address so it can be compared with length
    assign w_last      = (r_idx == (r_len - c_CNT_ONE));
    assign w_accept    = (r_state == ST_IDLE) && start;
    assign w_rdsum_nxt = r_rdsum + mem_dout;

    assign mem_addr = r_base + r_idx[ADDR_W-1:0];
    assign mem_din  = s_data;
    assign checksum = r_checksum;
    assign err      = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        s_ready     = 1'b0;
        mem_we      = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        w_xfer      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_nxt = (length == c_CNT_ZERO) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    w_xfer = 1'b1;
                    mem_we = 1'b1;
                    if (w_last) begin
                        w_state_nxt = ST_VERIFY;
                    end
                end
            end
            ST_VERIFY: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_base     <= '0;
            r_len      <= '0;
            r_idx      <= '0;
            r_checksum <= '0;
            r_rdsum    <= '0;
            r_err      <= 1'b0;
        end else if (w_accept) begin
            r_base     <= base_addr;
            r_len      <= length;
            r_idx      <= '0;
            r_checksum <= '0;
            r_rdsum    <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_xfer) begin
                        r_checksum <= r_checksum + s_data;
                        r_idx      <= w_last ? c_CNT_ZERO : (r_idx + c_CNT_ONE);
                    end
                end
                ST_VERIFY: begin
                    // The final readback word is folded in on the same edge the compare is made
                    r_rdsum <= w_rdsum_nxt;
                    if (w_last) begin
                        r_idx <= '0;
                        r_err <= (w_rdsum_nxt != r_checksum);
                    end else begin
                        r_idx <= r_idx + c_CNT_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
